// File: rtl/agc_ctrl.sv
// agc_ctrl: sequencing controller for the AGC datapath.
// Gates samples into the AGC multiplier, aligns the gain-update strobe with
// the AGC's 3-stage pipeline and runs an acquire/track/hold loop on the
// AGC output magnitude, decimating gain updates while locked.
//
// Ports:
//   clk, nrst          clock, asynchronous active-low reset
//   start              (re)start acquisition, level-sampled
//   freeze             hold the gain while high
//   in_valid           input sample strobe
//   agc_out_real/imag  AGC output sample, two's complement
//   agc_en             AGC multiplier enable (combinational)
//   agc_gain_en        AGC gain-register update enable
//   out_valid          AGC output valid strobe
//   locked             registered lock flag
//   state              IDLE=0, ACQUIRE=1, TRACK=2, HOLD=3
module agc_ctrl #(
  parameter int SAMPLE_WH      = 16,
  parameter int R_VALUE        = 6553,
  parameter int LOCK_TOL       = 655,
  parameter int LOSS_TOL       = 1638,
  parameter int LOCK_CNT       = 64,
  parameter int LOSS_CNT       = 16,
  parameter int TRACK_DEC_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start,
  input  logic                 freeze,
  input  logic                 in_valid,
  input  logic [SAMPLE_WH-1:0] agc_out_real,
  input  logic [SAMPLE_WH-1:0] agc_out_imag,
  output logic                 agc_en,
  output logic                 agc_gain_en,
  output logic                 out_valid,
  output logic                 locked,
  output logic [1:0]           state
);

  localparam int STAGES = 3;
  localparam int LKW    = $clog2(LOCK_CNT + 1);
  localparam int LSW    = $clog2(LOSS_CNT + 1);
  localparam int DW     = (TRACK_DEC_LOG2 > 0) ? TRACK_DEC_LOG2 : 1;

  localparam logic [SAMPLE_WH:0] RV  = R_VALUE[SAMPLE_WH:0];
  localparam logic [SAMPLE_WH:0] LKT = LOCK_TOL[SAMPLE_WH:0];
  localparam logic [SAMPLE_WH:0] LST = LOSS_TOL[SAMPLE_WH:0];

  typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, TRACK = 2'd2, HOLD = 2'd3} state_t;

  state_t               st_q, st_nx;
  logic                 locked_nx, clr;
  logic [LKW-1:0]       lock_q, lock_nx;
  logic [LSW-1:0]       loss_q, loss_nx;
  logic [DW-1:0]        dec_q;
  logic [STAGES:1]      vld_pipe, tag_pipe;
  logic [SAMPLE_WH-1:0] abs_re, abs_im, mag_q;
  logic [SAMPLE_WH:0]   mag_x, err;
  logic                 acc, tag, eval, hit, miss;

  // |x| with the most negative code clipped to the most positive one
  function automatic logic [SAMPLE_WH-1:0] sat_abs(input logic [SAMPLE_WH-1:0] x);
    if (!x[SAMPLE_WH-1])                            sat_abs = x;
    else if (x == {1'b1, {(SAMPLE_WH-1){1'b0}}})    sat_abs = {1'b0, {(SAMPLE_WH-1){1'b1}}};
    else                                            sat_abs = -x;
  endfunction

  assign abs_re = sat_abs(agc_out_real);
  assign abs_im = sat_abs(agc_out_imag);

  // mag_q holds the sample whose out_valid was last cycle; vld_pipe[3] marks it
  assign mag_x = {1'b0, mag_q};
  assign err   = (mag_x >= RV) ? (mag_x - RV) : (RV - mag_x);
  assign eval  = vld_pipe[STAGES];
  assign hit   = (err <= LKT);
  assign miss  = (err > LST);

  // state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st_q   <= IDLE;
      locked <= 1'b0;
      lock_q <= '0;
      loss_q <= '0;
    end else begin
      st_q   <= st_nx;
      locked <= locked_nx;
      lock_q <= lock_nx;
      loss_q <= loss_nx;
    end
  end

  // next-state logic
  always_comb begin
    st_nx     = st_q;
    locked_nx = locked;
    lock_nx   = lock_q;
    loss_nx   = loss_q;
    clr       = 1'b0;
    if (st_q != IDLE && freeze) begin
      st_nx     = HOLD;
      locked_nx = 1'b0;
      clr       = 1'b1;
    end else if (st_q == HOLD) begin
      st_nx = ACQUIRE;
      clr   = 1'b1;
    end else if (start) begin
      st_nx     = ACQUIRE;
      locked_nx = 1'b0;
      clr       = 1'b1;
    end else if (eval && st_q == ACQUIRE) begin
      if (!hit) lock_nx = '0;
      else if (lock_q == LKW'(LOCK_CNT - 1)) begin
        st_nx     = TRACK;
        locked_nx = 1'b1;
        clr       = 1'b1;
      end else lock_nx = lock_q + 1'b1;
    end else if (eval && st_q == TRACK) begin
      if (!miss) loss_nx = '0;
      else if (loss_q == LSW'(LOSS_CNT - 1)) begin
        st_nx     = ACQUIRE;
        locked_nx = 1'b0;
        clr       = 1'b1;
      end else loss_nx = loss_q + 1'b1;
    end
    if (clr) begin
      lock_nx = '0;
      loss_nx = '0;
    end
  end

  // output logic
  always_comb begin
    acc = in_valid && (st_q != IDLE);
    tag = 1'b0;
    case (st_q)
      ACQUIRE: tag = acc;
      TRACK:   tag = acc && (dec_q == '0);
      default: tag = 1'b0;
    endcase
  end

  // tag/valid pipes mirror the AGC latency; in-flight tags always drain
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      mag_q    <= '0;
      dec_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], acc};
      tag_pipe <= {tag_pipe[STAGES-1:1], tag};
      if (vld_pipe[2]) mag_q <= (abs_re >= abs_im) ? abs_re : abs_im;
      // held at zero outside TRACK so the first TRACK sample updates
      if (st_q != TRACK) dec_q <= '0;
      else if (acc && TRACK_DEC_LOG2 > 0) dec_q <= dec_q + 1'b1;
    end
  end

  assign agc_en      = acc;
  assign out_valid   = vld_pipe[2];
  assign agc_gain_en = tag_pipe[STAGES];
  assign state       = st_q;

endmodule

// File: tb/tb_agc_ctrl.sv
module tb_agc_ctrl;
  localparam int W = 16, RV = 6553, LKT = 655, LST = 1638, LKC = 64, LSC = 16, DL = 2;

  logic clk = 0, nrst = 0, start = 0, freeze = 0, in_valid = 0;
  logic signed [W-1:0] agc_out_real = '0, agc_out_imag = '0;
  logic agc_en, agc_gain_en, out_valid, locked;
  logic [1:0] state;

  agc_ctrl #(.SAMPLE_WH(W), .R_VALUE(RV), .LOCK_TOL(LKT), .LOSS_TOL(LST),
             .LOCK_CNT(LKC), .LOSS_CNT(LSC), .TRACK_DEC_LOG2(DL)) dut (
    .clk(clk), .nrst(nrst), .start(start), .freeze(freeze), .in_valid(in_valid),
    .agc_out_real(agc_out_real), .agc_out_imag(agc_out_imag),
    .agc_en(agc_en), .agc_gain_en(agc_gain_en), .out_valid(out_valid),
    .locked(locked), .state(state));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: timeline of scheduled events per cycle
  int m_state = 0, m_locked = 0, lock_c = 0, loss_c = 0, trk_n = 0;
  bit ov_s[8], ge_s[8], ev_s[8];
  int ev_m[8];
  int cyc = 0, pat = 0, gcount = 0;
  int qre[$], qim[$];

  function automatic int mag_of(input int re, input int im);
    int a, b;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    if (a > 32767) a = 32767;
    if (b > 32767) b = 32767;
    return (a > b) ? a : b;
  endfunction

  // AGC output value for a sample, chosen by the current pattern
  task automatic gen(output int re, output int im);
    int d[4];
    d[0] = LKT; d[1] = LKT + 1; d[2] = LST; d[3] = LST + 1;
    case (pat)
      1: begin
        re = RV + int'($urandom_range(0, 200)) - 100;
        im = int'($urandom_range(0, 2000)) - 1000;
        if ($urandom_range(0, 1) == 1) re = -re;
      end
      2: begin re = 0; im = 0; end
      3: begin re = -32768; im = -32768; end
      4: begin re = RV; im = 0; end
      5: begin
        re = ($urandom_range(0, 1) == 1) ? RV + d[$urandom_range(0, 3)] : RV - d[$urandom_range(0, 3)];
        im = 0;
      end
      default: begin
        re = int'($urandom_range(0, 65535)) - 32768;
        im = int'($urandom_range(0, 65535)) - 32768;
      end
    endcase
  endtask

  task automatic model_clear();
    m_state = 0; m_locked = 0; lock_c = 0; loss_c = 0; trk_n = 0;
    for (int i = 0; i < 8; i++) begin ov_s[i] = 0; ge_s[i] = 0; ev_s[i] = 0; ev_m[i] = 0; end
    qre.delete(); qim.delete();
  endtask

  // one clock cycle: drive, check at negedge, advance the model over the edge
  task automatic step(input bit inv, input bit st, input bit fr);
    int i, re, im, mg, err, ns, nl;
    bit acc, tag, ev;
    i = cyc % 8;
    in_valid = inv; start = st; freeze = fr;
    if (ov_s[i] && qre.size() > 0) begin
      agc_out_real = 16'(qre.pop_front());
      agc_out_imag = 16'(qim.pop_front());
    end else begin
      agc_out_real = 16'($urandom);
      agc_out_imag = 16'($urandom);
    end
    @(negedge clk);
    acc = inv && (m_state != 0);
    chk("agc_en", agc_en, acc);
    chk("out_valid", out_valid, ov_s[i]);
    chk("agc_gain_en", agc_gain_en, ge_s[i]);
    chk("state", state, m_state);
    chk("locked", locked, m_locked);
    gcount += int'(agc_gain_en);

    tag = acc && (m_state == 1 || (m_state == 2 && (trk_n % (1 << DL)) == 0));
    if (acc && m_state == 2) trk_n++;
    ov_s[(cyc + 2) % 8] = acc;
    ge_s[(cyc + 3) % 8] = tag;
    if (acc) begin gen(re, im); qre.push_back(re); qim.push_back(im); end
    ev = ev_s[i]; mg = ev_m[i];
    if (ov_s[i]) begin
      ev_s[(cyc + 1) % 8] = 1;
      ev_m[(cyc + 1) % 8] = mag_of(int'(agc_out_real), int'(agc_out_imag));
    end
    ov_s[i] = 0; ge_s[i] = 0; ev_s[i] = 0;
    err = (mg > RV) ? mg - RV : RV - mg;
    ns = m_state; nl = m_locked;
    if (m_state != 0 && fr) begin ns = 3; nl = 0; lock_c = 0; loss_c = 0; end
    else if (m_state == 3) begin ns = 1; lock_c = 0; loss_c = 0; end
    else if (st) begin ns = 1; nl = 0; lock_c = 0; loss_c = 0; end
    else if (m_state == 1 && ev) begin
      if (err <= LKT) begin
        lock_c++;
        if (lock_c == LKC) begin ns = 2; nl = 1; end
      end else lock_c = 0;
    end else if (m_state == 2 && ev) begin
      if (err > LST) begin
        loss_c++;
        if (loss_c == LSC) begin ns = 1; nl = 0; end
      end else loss_c = 0;
    end
    if (ns != m_state) begin lock_c = 0; loss_c = 0; if (ns == 2) trk_n = 0; end
    m_state = ns; m_locked = nl;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    nrst = 0; in_valid = 0; start = 0; freeze = 0;
    #1;
    chk("rst_agc_en", agc_en, 0);
    chk("rst_gain_en", agc_gain_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_state", state, 0);
    model_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;
    nrst = 1;
  endtask

  task automatic run(input int n, input bit inv);
    for (int k = 0; k < n; k++) step(inv, 0, 0);
  endtask

  initial begin
    model_clear();
    nrst = 0;
    in_valid = 1;
    #2;
    chk("rst_agc_en", agc_en, 0);
    chk("rst_gain_en", agc_gain_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_state", state, 0);
    @(posedge clk); #1;
    nrst = 1;

    // idle: samples without start are not accepted
    for (int k = 0; k < 6; k++) step(k % 3 != 2, 0, 0);

    // alignment: 10 back-to-back plus one isolated sample
    pat = 2;
    step(0, 1, 0);
    gcount = 0;
    run(10, 1);
    run(2, 0);
    run(1, 1);
    run(6, 0);
    chk("align_pulses", gcount, 11);

    // lock: saturated sample early resets the lock counter
    pat = 1;
    step(0, 1, 0);
    run(3, 1);
    pat = 3; run(1, 1);
    pat = 1; run(LKC, 1);
    run(10, 1);
    run(4, 0);
    chk("lock_state", state, 2);
    chk("lock_flag", locked, 1);
    gcount = 0;
    run(16, 1);
    run(4, 0);
    chk("track_decim", gcount, 4);

    // loss: a single hit breaks the miss run
    pat = 2; run(LSC - 1, 1);
    pat = 4; run(1, 1);
    pat = 2; run(LSC - 1, 1);
    chk("loss_hold", state, 2);
    run(1, 1);
    run(5, 0);
    chk("loss_state", state, 1);
    chk("loss_flag", locked, 0);

    // freeze under continuous samples
    pat = 0;
    run(5, 1);
    step(1, 0, 1);
    gcount = 0;
    for (int k = 0; k < 9; k++) step(1, 0, 1);
    chk("freeze_drain", gcount <= 3, 1);
    chk("freeze_state", state, 3);
    run(10, 1);

    // randomized segments
    for (int seg = 0; seg < 40; seg++) begin
      int len, r;
      r = $urandom_range(0, 9);
      pat = (r <= 5) ? 1 : (r == 6) ? 0 : (r == 7) ? 2 : (r == 8) ? 4 : 5;
      len = $urandom_range(20, 120);
      for (int k = 0; k < len; k++)
        step($urandom_range(0, 9) < 8, $urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) do_reset();
    end

    // reset with samples in flight in TRACK
    pat = 1;
    step(0, 1, 0);
    run(LKC + 6, 1);
    run(5, 0);
    chk("pre_rst_state", state, 2);
    run(3, 1);
    do_reset();
    gcount = 0;
    run(8, 0);
    chk("post_rst_pulses", gcount, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/agc_ctrl.md
# agc_ctrl

Sequencing controller for the AGC datapath. It gates sample entry into the AGC multiplier (`agc_en`) and aligns the gain-update strobe (`agc_gain_en`) with the AGC's 3-stage internal pipeline. It monitors the AGC output magnitude to run an acquire/track/hold loop, decimating gain updates once the level is locked. It sits between the sample source and the AGC inside the RACE filter front end.

## Interface
- `SAMPLE_WH`, 16: AGC sample width, two's complement.
- `R_VALUE`, 6553: AGC reference level in sample LSBs (0.2 in Q1.15).
- `LOCK_TOL`, 655: in-window tolerance on |mag − R_VALUE| for lock.
- `LOSS_TOL`, 1638: out-of-window threshold for loss of lock.
- `LOCK_CNT`, 64: consecutive in-window samples required to lock (≥1).
- `LOSS_CNT`, 16: consecutive out-of-window samples required to drop lock (≥1).
- `TRACK_DEC_LOG2`, 2: in TRACK, one gain update per 2^N accepted samples.

Ports:
- `clk` in 1: clock.
- `nrst` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled. Starts from IDLE; restarts acquisition when running.
- `freeze` in 1: level. While high, hold the gain.
- `in_valid` in 1: input sample strobe, one cycle per sample; back-to-back allowed.
- `agc_out_real` in SAMPLE_WH: AGC output, real part.
- `agc_out_imag` in SAMPLE_WH: AGC output, imaginary part.
- `agc_en` out 1: AGC multiplier enable.
- `agc_gain_en` out 1: AGC gain-register update enable.
- `out_valid` out 1: AGC output valid strobe.
- `locked` out 1: registered lock flag.
- `state` out 2: IDLE=0, ACQUIRE=1, TRACK=2, HOLD=3.

## Operation
- Accepted sample: `in_valid`=1 and state≠IDLE.
- `agc_en` = `in_valid` & (state≠IDLE). This path is combinational.
- Update tag, computed when a sample is accepted:
  - ACQUIRE: 1.
  - TRACK: 1 when the decimation counter is 0.
  - HOLD: 0.
- The tag travels down a 3-deep shift register. `agc_gain_en` = tag stage 3.
- A parallel valid shift register produces `out_valid`.
- The decimation counter is TRACK_DEC_LOG2 bits wide. It increments per accepted sample in TRACK, wraps modulo 2^N, and clears on TRACK entry, so the first TRACK sample updates.
- Magnitude monitor, run on each `out_valid` cycle:
  - abs(re) and abs(im), with −2^(SAMPLE_WH−1) saturating to 2^(SAMPLE_WH−1)−1.
  - mag = max of the two, registered.
  - err = |mag − R_VALUE| in SAMPLE_WH+1 bits, unsigned compare.
  - The evaluation registers the lock/loss counters one cycle after `out_valid`.
- State transitions, highest priority first:
  - Any non-IDLE state with `freeze`=1: go to HOLD and clear `locked`.
  - HOLD with `freeze`=0: go to ACQUIRE.
  - `start`=1 in IDLE, ACQUIRE or TRACK: go to ACQUIRE, clear counters, clear `locked`.
  - ACQUIRE: an evaluation with err≤LOCK_TOL increments the lock counter; any other evaluation clears it. The LOCK_CNT-th consecutive hit goes to TRACK and sets `locked`=1.
  - TRACK: an evaluation with err>LOSS_TOL increments the loss counter; any other evaluation clears it. The LOSS_CNT-th consecutive miss goes to ACQUIRE and clears `locked`.
  - Evaluations in IDLE or HOLD are ignored. Counters clear on every state change.
- In-flight tags always drain, so up to 3 `agc_gain_en` pulses can follow HOLD entry. In HOLD, `agc_en` keeps passing samples at the frozen gain.

## Timing
- Reset (async, `nrst`=0):
  - state=IDLE, `locked`=0.
  - `agc_gain_en`=0, `out_valid`=0.
  - All shift registers and counters cleared.
  - `agc_en`=0 because state is IDLE.
- For a sample accepted in cycle n:
  - `agc_en` high in n.
  - `out_valid` high in n+2.
  - `agc_gain_en` high in n+3 if tagged.
  - The magnitude is evaluated at the end of n+3. Any resulting state/`locked` change is visible in n+4.
- Continuous `in_valid` gives continuous strobes. There is no stall and no backpressure.
- `start`/`freeze` are sampled at clock edges. The new state is visible the next cycle and governs tags for samples accepted from that cycle on.
- Reset mid-operation: all pending tags are discarded. No `agc_gain_en` pulse occurs after `nrst` is released until a new sample is accepted and tagged.

## Test plan
- Reset/idle: hold `nrst` low, then release and pulse `in_valid` without `start` → `agc_en`, `agc_gain_en`, `out_valid`, `locked` and `state` all stay 0.
- Alignment:
  - Stimulus: `start`, then 10 back-to-back `in_valid` plus one isolated `in_valid`.
  - Required: `agc_en` mirrors `in_valid`. Each sample gives `out_valid` at +2 and `agc_gain_en` at +3. Exactly 11 gain pulses.
- Lock and decimation:
  - Stimulus: drive `agc_out_real`=6553±100, `agc_out_imag`=0 for 64 samples, with one −32768/−32768 sample early on.
  - Required: the saturated sample resets the lock counter. `locked` rises the cycle after the 64th consecutive hit; `state`=2. Afterwards `agc_gain_en` fires on samples 0, 4, 8, … only.
- Loss: in TRACK, drive 15 samples with mag 0, then 1 with mag 6553, then 16 with mag 0 → no exit after the first run; after the 16th miss `state`=1 and `locked`=0.
- Freeze:
  - Stimulus: raise `freeze` in ACQUIRE under continuous samples.
  - Required: `state`=3 next cycle and ≤3 draining gain pulses, then none; `agc_en` continues. Dropping `freeze` gives `state`=1 and gain pulses resume 3 cycles after the next accepted sample.
- Reset mid-TRACK: assert `nrst` with 3 samples in flight → outputs are zero immediately; after release, no stray `agc_gain_en` or `out_valid`.
